fu_share_scheduler: RTL and testbench
=====================================

// Module: fu_share_scheduler
// PURPOSE
// - Shares NUM_UNITS identical non-pipelined, variable-latency functional units (e.g. dividers)
//   among NUM_REQ issue requesters (reservation-station ports) with rotating round-robin priority.
// - Grants up to NUM_UNITS requests per cycle, tracks unit occupancy and owner, and routes
//   unit completion back to the owning requester. Flush kills in-flight ownership.
// PARAMETERS
// - NUM_REQ    4   number of requesters (>=2)
// - NUM_UNITS  2   number of shared units (1..NUM_REQ)
// - REQ_W      $clog2(NUM_REQ)  owner index width (derived; do not override)
// PORTS
// - clk          in   1                  clock, all state on rising edge
// - rst          in   1                  asynchronous, active-high reset
// - flush        in   1                  pipeline flush; kills all in-flight ops
// - req_valid    in   NUM_REQ            requester i has an op ready to issue
// - req_ready    out  NUM_REQ            requester i granted this cycle (handshake = valid & ready)
// - issue_valid  out  NUM_UNITS          unit u starts an op this cycle
// - issue_src    out  NUM_UNITS x REQ_W  requester index feeding unit u's operand mux
// - unit_done    in   NUM_UNITS          unit u finished its op (1-cycle pulse)
// - done_valid   out  NUM_UNITS          unit u result is live; forward to owner
// - done_owner   out  NUM_UNITS x REQ_W  owner of unit u's result
// - unit_busy    out  NUM_UNITS          registered occupancy, for debug/perf counters
// - err_spurious out  1                  sticky: unit_done seen on a non-busy unit
// BEHAVIOUR
// - State: busy[u], killed[u], owner[u], ptr (REQ_W bits, head of priority), err flag.
// - Reset: busy=0, killed=0, owner=0, ptr=0, err_spurious=0; while rst=1 req_ready,
//   issue_valid, done_valid forced 0.
// - Free unit: free[u] = ~busy[u] | unit_done[u] (same-cycle reuse; back-to-back allowed).
// - Grant (combinational, zero latency): walk requesters from ptr upward mod NUM_REQ; k-th
//   valid requester found gets the k-th lowest-index free unit; stop when free units exhausted.
//   Each requester granted at most once per cycle. issue_src[u] = granted index.
// - flush=1: req_ready=0, issue_valid=0 that cycle (no new grants).
// - Pointer: on >=1 grant, ptr <= (index of last granted requester + 1) mod NUM_REQ; else hold.
//   Guarantees starvation freedom: a continuously valid requester waits <= ceil(NUM_REQ/NUM_UNITS)
//   grant rounds.
// - Issue: on issue_valid[u]: busy[u]<=1, owner[u]<=issue_src[u], killed[u]<=0.
// - Completion: unit_done[u] & busy[u]: busy[u]<=0 unless re-issued same cycle;
//   done_valid[u] = unit_done[u] & busy[u] & ~killed[u] & ~flush (combinational);
//   done_owner[u] = owner[u].
// - Flush: killed[u]<=1 for every busy[u] not completing that cycle; busy kept until unit_done
//   (hardware still computing); killed unit not grantable until its unit_done arrives.
// - Spurious done: unit_done[u] & ~busy[u] -> err_spurious<=1 (sticky until rst), else ignored.
// - Reset mid-operation: all state cleared immediately (async); late unit_done after reset
//   sets err_spurious; integration must reset units alongside.
// STRUCTURE
// - Package fu_sched_pkg: REQ_W helper function, typedef logic [REQ_W-1:0] req_idx_t,
//   unit_state_t struct {busy, killed, owner}.
// - Sub-module rr_pick_one: combinational rotating-priority single pick (req mask, ptr ->
//   one-hot + index + found); NUM_UNITS instances chained, each masking prior picks.
// - Top holds state regs, free-unit ordering, pointer update, done routing, error flag.
// TESTING
// - Reset, req_valid=4'b1111, no dones -> cycle 0 grants req0->unit0, req1->unit1; ptr=2.
// - Units busy, unit_done=2'b01 with req_valid=4'b0100 -> same cycle done_valid[0],
//   done_owner[0]=prior owner, req_ready=4'b0100, issue_src[0]=2, unit0 stays busy.
// - All 4 req valid, units freed every cycle for 8 cycles -> grant order 0,1,2,3,0,1,2,3
//   (pairs), no requester waits > 2 rounds.
// - Unit0 busy (owner 3), flush pulse, later unit_done[0] -> done_valid[0]=0, unit0 free next
//   cycle, grantable thereafter; flush cycle req_ready=0.
// - unit_done[1] while unit1 idle -> err_spurious=1 and stays 1; no done_valid.
// - Assert rst while both units busy -> unit_busy=0, ptr=0 immediately; after release,
//   req_valid=4'b1000 -> req_ready=4'b1000, issue_valid=2'b01.

Source files
------------

// File: rtl/fu_sched_pkg.sv
// Shared types for the functional-unit share scheduler: owner index and per-unit state.
package fu_sched_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_NUM_UNITS = 2;

  function automatic int req_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int PKG_REQ_W = req_w(DEF_NUM_REQ);

  typedef logic [PKG_REQ_W-1:0] req_idx_t;

  typedef struct packed {
    logic     busy;
    logic     killed;
    req_idx_t owner;
  } unit_state_t;

endpackage

// File: rtl/fu_share_scheduler_rr_pick_one.sv
// Rotating-priority single pick: first set request at or after ptr, wrapping mod N.
// Purely combinational, zero latency; no backpressure of its own.
module rr_pick_one #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W:0]     sum;

  always_comb begin
    // rot[i] corresponds to requester (ptr + i) mod N
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (W+1)'(i);
      end
    end
    if (sum >= (W+1)'(N)) begin
      sum = sum - (W+1)'(N);
    end
    idx = sum[W-1:0];
    gnt = '0;
    if (found) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/fu_share_scheduler.sv
// Round-robin share of NUM_UNITS non-pipelined units among NUM_REQ requesters.
// Grants and done routing are same-cycle combinational; a requester waits while no unit is free or flush is high.
module fu_share_scheduler
  import fu_sched_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int NUM_UNITS = DEF_NUM_UNITS,
  parameter int REQ_W     = req_w(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_UNITS-1:0]              issue_valid,
  output logic [NUM_UNITS-1:0][REQ_W-1:0]   issue_src,
  input  logic [NUM_UNITS-1:0]              unit_done,
  output logic [NUM_UNITS-1:0]              done_valid,
  output logic [NUM_UNITS-1:0][REQ_W-1:0]   done_owner,
  output logic [NUM_UNITS-1:0]              unit_busy,
  output logic                              err_spurious
);

  unit_state_t [NUM_UNITS-1:0] st_q, st_d;
  logic [REQ_W-1:0]            ptr_q, ptr_d;
  logic                        err_q, err_d;

  logic [NUM_UNITS-1:0]              busy_vec;
  logic [NUM_UNITS-1:0]              free;
  logic [NUM_UNITS:0][NUM_REQ-1:0]   mask;
  logic [NUM_UNITS-1:0][NUM_REQ-1:0] pick_gnt;
  logic [NUM_UNITS-1:0][REQ_W-1:0]   pick_idx;
  logic [NUM_UNITS-1:0]              pick_found;
  logic [REQ_W-1:0]                  last_idx;
  logic [REQ_W:0]                    ptr_inc;
  logic                              any_gnt;
  int                                rank;

  // Each stage picks the next requester in rotation after removing earlier picks.
  assign mask[0] = req_valid;

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_pick
    rr_pick_one #(
      .N (NUM_REQ),
      .W (REQ_W)
    ) u_pick (
      .req   (mask[k]),
      .ptr   (ptr_q),
      .gnt   (pick_gnt[k]),
      .idx   (pick_idx[k]),
      .found (pick_found[k])
    );
    assign mask[k+1] = mask[k] & ~pick_gnt[k];
  end

  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      busy_vec[u] = st_q[u].busy;
    end
    free = ~busy_vec | unit_done;
  end

  // The k-th pick lands on the k-th lowest-index free unit; surplus picks are dropped.
  always_comb begin
    req_ready   = '0;
    issue_valid = '0;
    issue_src   = '0;
    last_idx    = '0;
    any_gnt     = 1'b0;
    rank        = 0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (free[u]) begin
        for (int k = 0; k < NUM_UNITS; k++) begin
          if (rank == k && pick_found[k] && !flush && !rst) begin
            issue_valid[u] = 1'b1;
            issue_src[u]   = pick_idx[k];
            req_ready      = req_ready | pick_gnt[k];
            last_idx       = pick_idx[k];
            any_gnt        = 1'b1;
          end
        end
        rank = rank + 1;
      end
    end
  end

  always_comb begin
    ptr_inc = {1'b0, last_idx} + 1'b1;
    if (ptr_inc >= (REQ_W+1)'(NUM_REQ)) begin
      ptr_inc = '0;
    end
    ptr_d = any_gnt ? ptr_inc[REQ_W-1:0] : ptr_q;
  end

  always_comb begin
    st_d  = st_q;
    err_d = err_q | (|(unit_done & ~busy_vec));
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (unit_done[u] && st_q[u].busy) begin
        st_d[u].busy = 1'b0;
      end else if (flush && st_q[u].busy) begin
        // Unit keeps computing; its eventual result is discarded.
        st_d[u].killed = 1'b1;
      end
      if (issue_valid[u]) begin
        st_d[u].busy   = 1'b1;
        st_d[u].killed = 1'b0;
        st_d[u].owner  = req_idx_t'(issue_src[u]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      done_valid[u] = unit_done[u] & st_q[u].busy & ~st_q[u].killed & ~flush & ~rst;
      done_owner[u] = REQ_W'(st_q[u].owner);
    end
  end

  assign unit_busy    = busy_vec;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_fu_share_scheduler.sv
// Randomized and directed bench for fu_share_scheduler against a queue-based reference model.
module tb_fu_share_scheduler;

  localparam int NR = 4;
  localparam int NU = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic [NR-1:0]       req_valid;
  logic [NR-1:0]       req_ready;
  logic [NU-1:0]       issue_valid;
  logic [NU-1:0][1:0]  issue_src;
  logic [NU-1:0]       unit_done;
  logic [NU-1:0]       done_valid;
  logic [NU-1:0][1:0]  done_owner;
  logic [NU-1:0]       unit_busy;
  logic                err_spurious;

  int checks = 0;
  int errors = 0;

  int m_busy   [NU];
  int m_killed [NU];
  int m_owner  [NU];
  int m_ptr;
  int m_err;

  logic [NR-1:0] obs_rdy;
  logic [NU-1:0] obs_iss;
  logic [NU-1:0] obs_dv;
  logic [1:0]    obs_src0;

  fu_share_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .issue_valid  (issue_valid),
    .issue_src    (issue_src),
    .unit_done    (unit_done),
    .done_valid   (done_valid),
    .done_owner   (done_owner),
    .unit_busy    (unit_busy),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NU-1:0] model_busy_vec();
    logic [NU-1:0] v;
    for (int u = 0; u < NU; u++) v[u] = (m_busy[u] != 0);
    return v;
  endfunction

  task automatic model_clear();
    for (int u = 0; u < NU; u++) begin
      m_busy[u] = 0; m_killed[u] = 0; m_owner[u] = 0;
    end
    m_ptr = 0;
    m_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '1; unit_done = '0; flush = 1'b0;
    #1;
    model_clear();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_issue_valid", 32'(issue_valid), 32'h0);
    check("rst_done_valid", 32'(done_valid), 32'h0);
    check("rst_unit_busy", 32'(unit_busy), 32'h0);
    check("rst_err", 32'(err_spurious), 32'h0);
    @(negedge clk);
    rst = 1'b0; req_valid = '0;
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered state after the edge.
  task automatic cycle(input logic [NR-1:0] rv, input logic [NU-1:0] ud, input logic fl);
    logic [NR-1:0] e_rdy;
    logic [NU-1:0] e_iss;
    logic [NU-1:0] e_dv;
    int            e_src [NU];
    int            freeq [$];
    int            nu;
    int            last;
    int            r;
    @(negedge clk);
    req_valid = rv; unit_done = ud; flush = fl;
    #1;
    e_rdy = '0; e_iss = '0; e_dv = '0; nu = 0; last = 0;
    for (int u = 0; u < NU; u++) begin
      e_src[u] = 0;
      if (m_busy[u] == 0 || ud[u]) freeq.push_back(u);
    end
    if (!fl) begin
      for (int i = 0; i < NR; i++) begin
        r = (m_ptr + i) % NR;
        if (rv[r] && nu < freeq.size()) begin
          e_iss[freeq[nu]] = 1'b1;
          e_src[freeq[nu]] = r;
          e_rdy[r] = 1'b1;
          last = r;
          nu++;
        end
      end
    end
    for (int u = 0; u < NU; u++)
      e_dv[u] = ud[u] && m_busy[u] != 0 && m_killed[u] == 0 && !fl;

    obs_rdy = req_ready; obs_iss = issue_valid; obs_dv = done_valid; obs_src0 = issue_src[0];
    check("req_ready", 32'(req_ready), 32'(e_rdy));
    check("issue_valid", 32'(issue_valid), 32'(e_iss));
    check("done_valid", 32'(done_valid), 32'(e_dv));
    for (int u = 0; u < NU; u++) begin
      if (e_iss[u]) check("issue_src", 32'(issue_src[u]), 32'(e_src[u]));
      if (e_dv[u]) check("done_owner", 32'(done_owner[u]), 32'(m_owner[u]));
    end

    @(posedge clk);
    for (int u = 0; u < NU; u++) begin
      if (ud[u] && m_busy[u] == 0) m_err = 1;
      if (ud[u] && m_busy[u] != 0) m_busy[u] = 0;
      else if (fl && m_busy[u] != 0) m_killed[u] = 1;
      if (e_iss[u]) begin
        m_busy[u] = 1; m_killed[u] = 0; m_owner[u] = e_src[u];
      end
    end
    if (nu > 0) m_ptr = (last + 1) % NR;
    #1;
    check("unit_busy", 32'(unit_busy), 32'(model_busy_vec()));
    check("err_spurious", 32'(err_spurious), 32'(m_err));
  endtask

  initial begin
    logic [NU-1:0] ud;
    rst = 1'b1; flush = 1'b0; req_valid = '0; unit_done = '0;
    model_clear();
    do_reset();

    // First grant after reset: req0 -> unit0, req1 -> unit1.
    cycle(4'b1111, 2'b00, 1'b0);
    check("first_grant", 32'(obs_rdy), 32'h3);
    // Same-cycle completion and reuse of unit0 by req2.
    cycle(4'b0100, 2'b01, 1'b0);
    check("reuse_rdy", 32'(obs_rdy), 32'h4);
    check("reuse_dv", 32'(obs_dv), 32'h1);
    check("reuse_src", 32'(obs_src0), 32'h2);
    // req3 takes unit0, then flush kills it.
    cycle(4'b1000, 2'b01, 1'b0);
    cycle(4'b1111, 2'b10, 1'b1);
    check("flush_rdy", 32'(obs_rdy), 32'h0);
    cycle(4'b0000, 2'b01, 1'b0);
    check("killed_dv", 32'(obs_dv), 32'h0);
    cycle(4'b0001, 2'b00, 1'b0);
    check("post_kill_iss", 32'(obs_iss), 32'h1);

    // Saturated round robin: pairs alternate {0,1},{2,3}.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cycle(4'b1111, (c == 0) ? 2'b00 : 2'b11, 1'b0);
      check("rr_order", 32'(obs_rdy), (c % 2 == 0) ? 32'h3 : 32'hc);
    end

    // Reset with both units busy; pointer back at 0 afterwards.
    do_reset();
    cycle(4'b1000, 2'b00, 1'b0);
    check("post_rst_rdy", 32'(obs_rdy), 32'h8);
    check("post_rst_iss", 32'(obs_iss), 32'h1);

    // Random traffic with legal completions only.
    for (int n = 0; n < 400; n++) begin
      ud = '0;
      for (int u = 0; u < NU; u++)
        if (m_busy[u] != 0 && $urandom_range(0, 2) == 0) ud[u] = 1'b1;
      cycle(4'($urandom_range(0, 15)), ud, ($urandom_range(0, 9) == 0));
    end

    // Spurious completion on an idle unit is sticky.
    do_reset();
    cycle(4'b0000, 2'b10, 1'b0);
    check("spur_dv", 32'(obs_dv), 32'h0);
    check("spur_err", 32'(err_spurious), 32'h1);
    cycle(4'b1111, 2'b00, 1'b0);
    cycle(4'b0000, 2'b11, 1'b0);
    check("spur_sticky", 32'(err_spurious), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
